// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the phase monitor.
// Helpers work on a zero-extended code of up to JC_MAX_W bits plus the actual width.
package johnson_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } jpm_state_t;

    localparam int unsigned JC_MAX_W = 32;

    // Next code in the Johnson sequence: shift right, inverted LSB enters at the MSB.
    function automatic logic [JC_MAX_W-1:0] jc_succ(input logic [JC_MAX_W-1:0] c,
                                                    input int unsigned         w);
        logic [JC_MAX_W-1:0] s;
        s        = c >> 1;
        s[w-1]   = ~c[0];
        return s;
    endfunction

    function automatic int unsigned jc_ones(input logic [JC_MAX_W-1:0] c,
                                            input int unsigned         w);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < JC_MAX_W; i++) begin
            if (i < w && c[i]) n++;
        end
        return n;
    endfunction

    // Legal codes are a single run of ones touching the MSB or the LSB.
    function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] c,
                                         input int unsigned         w);
        int unsigned         n;
        logic [JC_MAX_W-1:0] msb_run;
        logic [JC_MAX_W-1:0] lsb_run;
        n       = jc_ones(c, w);
        msb_run = '0;
        lsb_run = '0;
        for (int unsigned i = 0; i < JC_MAX_W; i++) begin
            if (i < w) begin
                if (i < n)     lsb_run[i] = 1'b1;
                if (i >= w - n) msb_run[i] = 1'b1;
            end
        end
        return (c == msb_run) || (c == lsb_run);
    endfunction

    // MSB-anchored runs (and all-zero) are phases 0..w; LSB-only runs are w+1..2w-1.
    function automatic int unsigned jc_phase(input logic [JC_MAX_W-1:0] c,
                                             input int unsigned         w);
        int unsigned n;
        n = jc_ones(c, w);
        if (n == 0 || c[w-1]) return n;
        return 2 * w - n;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational decode of a Johnson code into legality, phase index and one-hot phase.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]             code,
    output logic                         legal,
    output logic [$clog2(2*WIDTH)-1:0]   phase,
    output logic [2*WIDTH-1:0]           onehot
);

    localparam int unsigned PW = $clog2(2 * WIDTH);

    // Decode is only meaningful when legal is high; phase stays in range regardless.
    always_comb begin
        legal         = jc_is_legal(JC_MAX_W'(code), WIDTH);
        phase         = PW'(jc_phase(JC_MAX_W'(code), WIDTH));
        onehot        = '0;
        onehot[phase] = 1'b1;
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Tracks a Johnson counter: decodes phase, checks legality and succession,
// counts revolutions and raises registered error/status flags.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned REV_W      = 8,
    parameter bit          ALLOW_HOLD = 1'b1
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             cnt_in,
    input  logic                         cnt_valid,
    input  logic                         cnt_load,
    input  logic                         err_clr,
    output logic [$clog2(2*WIDTH)-1:0]   phase,
    output logic [2*WIDTH-1:0]           phase_onehot,
    output logic                         locked,
    output logic                         wrap_pulse,
    output logic [REV_W-1:0]             rev_count,
    output logic                         illegal,
    output logic                         skip_err,
    output logic                         err_sticky
);

    localparam int unsigned     PW         = $clog2(2 * WIDTH);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(2 * WIDTH - 1);

    jpm_state_t         state;
    logic [WIDTH-1:0]   prev_code;
    logic [WIDTH-1:0]   succ_code;
    logic               dec_legal;
    logic [PW-1:0]      dec_phase;
    logic [2*WIDTH-1:0] dec_onehot;

    johnson_code_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .code   (cnt_in),
        .legal  (dec_legal),
        .phase  (dec_phase),
        .onehot (dec_onehot)
    );

    assign succ_code = WIDTH'(jc_succ(JC_MAX_W'(prev_code), WIDTH));

    // Lock FSM plus all registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= UNLOCKED;
            prev_code    <= '0;
            phase        <= '0;
            phase_onehot <= '0;
            locked       <= 1'b0;
            wrap_pulse   <= 1'b0;
            rev_count    <= '0;
            illegal      <= 1'b0;
            skip_err     <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            illegal    <= 1'b0;
            skip_err   <= 1'b0;
            // A new error in the same cycle overrides this below.
            if (err_clr) err_sticky <= 1'b0;

            if (cnt_valid) begin
                if (!dec_legal) begin
                    // Illegal code faults from any state, load or not; phase holds.
                    state        <= FAULT;
                    illegal      <= 1'b1;
                    err_sticky   <= 1'b1;
                    locked       <= 1'b0;
                    phase_onehot <= '0;
                end else if (cnt_load) begin
                    state        <= LOCKED;
                    prev_code    <= cnt_in;
                    phase        <= dec_phase;
                    phase_onehot <= dec_onehot;
                    locked       <= 1'b1;
                end else begin
                    case (state)
                        UNLOCKED: begin
                            state        <= LOCKED;
                            prev_code    <= cnt_in;
                            phase        <= dec_phase;
                            phase_onehot <= dec_onehot;
                            locked       <= 1'b1;
                        end
                        LOCKED: begin
                            if (cnt_in == succ_code) begin
                                prev_code    <= cnt_in;
                                phase        <= dec_phase;
                                phase_onehot <= dec_onehot;
                                if (phase == LAST_PHASE) begin
                                    wrap_pulse <= 1'b1;
                                    rev_count  <= rev_count + 1'b1;
                                end
                            end else if (cnt_in == prev_code && ALLOW_HOLD) begin
                                // Stalled counter: keep everything as is.
                            end else begin
                                state        <= UNLOCKED;
                                prev_code    <= cnt_in;
                                phase        <= dec_phase;
                                phase_onehot <= '0;
                                locked       <= 1'b0;
                                skip_err     <= 1'b1;
                                err_sticky   <= 1'b1;
                            end
                        end
                        FAULT: begin
                            // Recover to UNLOCKED first; locking needs another legal sample.
                            state     <= UNLOCKED;
                            prev_code <= cnt_in;
                            phase     <= dec_phase;
                        end
                        default: begin
                            state        <= UNLOCKED;
                            phase_onehot <= '0;
                            locked       <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
module tb_johnson_phase_monitor;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic       cnt_valid = 1'b0;
    logic       cnt_load = 1'b0;
    logic       err_clr = 1'b0;

    // Index 0: ALLOW_HOLD=1, index 1: ALLOW_HOLD=0.
    logic [2:0] o_ph [2];
    logic [7:0] o_oh [2];
    logic       o_lk [2];
    logic       o_wp [2];
    logic [7:0] o_rc [2];
    logic       o_il [2];
    logic       o_sk [2];
    logic       o_es [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: state 0=unlocked 1=locked 2=fault, phase as plain integer.
    logic [3:0] codes [8];
    int m_st [2];
    int m_ph [2];
    int m_rev [2];
    bit m_wrap [2];
    bit m_ill [2];
    bit m_skip [2];
    bit m_sticky [2];

    always #5 clk = ~clk;

    johnson_phase_monitor #(.WIDTH(4), .REV_W(8), .ALLOW_HOLD(1'b1)) dut (
        .clk(clk), .clear(clear), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
        .cnt_load(cnt_load), .err_clr(err_clr), .phase(o_ph[0]), .phase_onehot(o_oh[0]),
        .locked(o_lk[0]), .wrap_pulse(o_wp[0]), .rev_count(o_rc[0]), .illegal(o_il[0]),
        .skip_err(o_sk[0]), .err_sticky(o_es[0])
    );

    johnson_phase_monitor #(.WIDTH(4), .REV_W(8), .ALLOW_HOLD(1'b0)) dut_nh (
        .clk(clk), .clear(clear), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
        .cnt_load(cnt_load), .err_clr(err_clr), .phase(o_ph[1]), .phase_onehot(o_oh[1]),
        .locked(o_lk[1]), .wrap_pulse(o_wp[1]), .rev_count(o_rc[1]), .illegal(o_il[1]),
        .skip_err(o_sk[1]), .err_sticky(o_es[1])
    );

    function automatic int code_index(input logic [3:0] c);
        for (int k = 0; k < 8; k++) if (codes[k] == c) return k;
        return -1;
    endfunction

    task automatic model_update();
        int idx;
        idx = code_index(cnt_in);
        for (int h = 0; h < 2; h++) begin
            m_wrap[h] = 0; m_ill[h] = 0; m_skip[h] = 0;
            if (clear) begin
                m_st[h] = 0; m_ph[h] = 0; m_rev[h] = 0; m_sticky[h] = 0;
            end else begin
                if (cnt_valid) begin
                    if (idx < 0) begin
                        m_st[h] = 2; m_ill[h] = 1;
                    end else if (cnt_load || m_st[h] == 0) begin
                        m_st[h] = 1; m_ph[h] = idx;
                    end else if (m_st[h] == 2) begin
                        m_st[h] = 0; m_ph[h] = idx;
                    end else if (idx == (m_ph[h] + 1) % 8) begin
                        if (m_ph[h] == 7) begin
                            m_wrap[h] = 1; m_rev[h] = (m_rev[h] + 1) % 256;
                        end
                        m_ph[h] = idx;
                    end else if (idx == m_ph[h] && h == 0) begin
                        // hold
                    end else begin
                        m_skip[h] = 1; m_st[h] = 0; m_ph[h] = idx;
                    end
                end
                if (m_ill[h] || m_skip[h]) m_sticky[h] = 1;
                else if (err_clr) m_sticky[h] = 0;
            end
        end
    endtask

    task automatic step(input bit v, input bit ld, input logic [3:0] c, input bit ec,
                        input bit cl);
        @(negedge clk);
        cnt_valid = v; cnt_load = ld; cnt_in = c; err_clr = ec; clear = cl;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 4'b0000, 0, 1);
        step(0, 0, 4'b0000, 0, 1);
        for (int h = 0; h < 2; h++) begin
            n_checks++;
            if ({o_ph[h], o_oh[h], o_lk[h], o_wp[h], o_rc[h], o_il[h], o_sk[h], o_es[h]} !== 24'd0)
                $display("FAIL reset[%0d]: ph=%0d oh=%h lk=%b wp=%b rc=%0d il=%b sk=%b es=%b, want all 0",
                         h, o_ph[h], o_oh[h], o_lk[h], o_wp[h], o_rc[h], o_il[h], o_sk[h], o_es[h]);
            else n_pass++;
        end
        step(1, 0, 4'b0000, 0, 0);
        n_checks++;
        if (o_lk[0] !== 1'b1) $display("FAIL first_lock: locked=%b want 1", o_lk[0]);
        else n_pass++;
        n_checks++;
        if (o_ph[0] !== 3'd0) $display("FAIL first_phase: phase=%0d want 0", o_ph[0]);
        else n_pass++;
        n_checks++;
        if (o_oh[0] !== 8'h01) $display("FAIL first_onehot: onehot=%h want 01", o_oh[0]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int wraps;
        wraps = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, codes[k % 8], 0, 0);
            if (o_wp[0] === 1'b1) wraps++;
        end
        n_checks++;
        if (wraps != 1) $display("FAIL wrap_once: wraps=%0d want 1", wraps);
        else n_pass++;
        n_checks++;
        if (o_rc[0] !== 8'd1) $display("FAIL rev_one: rev_count=%0d want 1", o_rc[0]);
        else n_pass++;
        wraps = 0;
        for (int lap = 0; lap < 255; lap++)
            for (int k = 1; k <= 8; k++) begin
                step(1, 0, codes[k % 8], 0, 0);
                if (o_wp[0] === 1'b1) wraps++;
            end
        n_checks++;
        if (wraps != 255) $display("FAIL wrap_count: wraps=%0d want 255", wraps);
        else n_pass++;
        n_checks++;
        if (o_rc[0] !== 8'd0) $display("FAIL rev_rollover: rev_count=%0d want 0", o_rc[0]);
        else n_pass++;
    endtask

    task automatic test_skip();
        step(1, 0, 4'b1000, 0, 0);
        step(1, 0, 4'b1100, 0, 0);
        step(1, 0, 4'b0011, 0, 0);
        n_checks++;
        if ({o_sk[0], o_es[0], o_lk[0]} !== 3'b110)
            $display("FAIL skip: sk=%b es=%b lk=%b want 1 1 0", o_sk[0], o_es[0], o_lk[0]);
        else n_pass++;
        n_checks++;
        if (o_ph[0] !== 3'd6) $display("FAIL skip_phase: phase=%0d want 6", o_ph[0]);
        else n_pass++;
        step(0, 0, 4'b0011, 1, 0);
        n_checks++;
        if ({o_sk[0], o_es[0]} !== 2'b00)
            $display("FAIL err_clr: sk=%b es=%b want 0 0", o_sk[0], o_es[0]);
        else n_pass++;
    endtask

    task automatic test_illegal();
        step(1, 0, 4'b1010, 0, 0);
        n_checks++;
        if ({o_il[0], o_lk[0], o_es[0]} !== 3'b101)
            $display("FAIL illegal: il=%b lk=%b es=%b want 1 0 1", o_il[0], o_lk[0], o_es[0]);
        else n_pass++;
        step(1, 0, 4'b0111, 0, 0);
        n_checks++;
        if ({o_il[0], o_lk[0]} !== 2'b00)
            $display("FAIL fault_recover: il=%b lk=%b want 0 0", o_il[0], o_lk[0]);
        else n_pass++;
        step(1, 0, 4'b0011, 0, 0);
        n_checks++;
        if ({o_lk[0], o_ph[0]} !== {1'b1, 3'd6})
            $display("FAIL relock: lk=%b phase=%0d want 1 6", o_lk[0], o_ph[0]);
        else n_pass++;
        step(0, 0, 4'b0011, 1, 0);
    endtask

    task automatic test_load();
        step(1, 1, 4'b1110, 0, 0);
        step(1, 1, 4'b0001, 0, 0);
        n_checks++;
        if ({o_lk[0], o_ph[0], o_sk[0], o_wp[0], o_es[0]} !== {1'b1, 3'd7, 3'b000})
            $display("FAIL load: lk=%b ph=%0d sk=%b wp=%b es=%b want 1 7 0 0 0",
                     o_lk[0], o_ph[0], o_sk[0], o_wp[0], o_es[0]);
        else n_pass++;
    endtask

    task automatic test_hold();
        step(1, 0, 4'b0000, 0, 0);
        step(1, 0, 4'b1000, 0, 0);
        step(1, 0, 4'b1100, 0, 0);
        step(1, 0, 4'b1110, 0, 0);
        step(1, 0, 4'b1111, 0, 0);
        step(1, 0, 4'b1111, 0, 0);
        n_checks++;
        if ({o_lk[0], o_ph[0], o_sk[0], o_es[0]} !== {1'b1, 3'd4, 2'b00})
            $display("FAIL hold_allowed: lk=%b ph=%0d sk=%b es=%b want 1 4 0 0",
                     o_lk[0], o_ph[0], o_sk[0], o_es[0]);
        else n_pass++;
        n_checks++;
        if ({o_lk[1], o_sk[1], o_es[1]} !== 3'b011)
            $display("FAIL hold_forbidden: lk=%b sk=%b es=%b want 0 1 1",
                     o_lk[1], o_sk[1], o_es[1]);
        else n_pass++;
    endtask

    task automatic test_clear();
        step(1, 0, 4'b1010, 0, 0);
        step(1, 1, 4'b0111, 0, 0);
        n_checks++;
        if ({o_lk[0], o_ph[0], o_es[0]} !== {1'b1, 3'd5, 1'b1})
            $display("FAIL pre_clear: lk=%b ph=%0d es=%b want 1 5 1", o_lk[0], o_ph[0], o_es[0]);
        else n_pass++;
        step(1, 0, 4'b0011, 0, 1);
        for (int h = 0; h < 2; h++) begin
            n_checks++;
            if ({o_ph[h], o_oh[h], o_lk[h], o_wp[h], o_rc[h], o_il[h], o_sk[h], o_es[h]} !== 24'd0)
                $display("FAIL mid_clear[%0d]: ph=%0d oh=%h lk=%b rc=%0d es=%b, want all 0",
                         h, o_ph[h], o_oh[h], o_lk[h], o_rc[h], o_es[h]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [7:0] exp_oh;
        int r;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      c = codes[(m_ph[0] + 1) % 8];
            else if (r < 8) c = codes[m_ph[0]];
            else if (r < 9) c = codes[$urandom_range(0, 7)];
            else            c = 4'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, c,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
            for (int h = 0; h < 2; h++) begin
                exp_oh = (m_st[h] == 1) ? 8'(1 << m_ph[h]) : 8'h00;
                n_checks++;
                if (o_ph[h] !== 3'(m_ph[h]) || o_oh[h] !== exp_oh || o_lk[h] !== (m_st[h] == 1) ||
                    o_wp[h] !== m_wrap[h] || o_rc[h] !== 8'(m_rev[h]) || o_il[h] !== m_ill[h] ||
                    o_sk[h] !== m_skip[h] || o_es[h] !== m_sticky[h])
                    $display("FAIL random[%0d] n=%0d: got ph=%0d oh=%h lk=%b wp=%b rc=%0d il=%b sk=%b es=%b want ph=%0d oh=%h lk=%b wp=%b rc=%0d il=%b sk=%b es=%b",
                             h, n, o_ph[h], o_oh[h], o_lk[h], o_wp[h], o_rc[h], o_il[h], o_sk[h],
                             o_es[h], m_ph[h], exp_oh, m_st[h] == 1, m_wrap[h], m_rev[h], m_ill[h],
                             m_skip[h], m_sticky[h]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            if (k <= 4) codes[k] = 4'(((1 << k) - 1) << (4 - k));
            else        codes[k] = 4'((1 << (8 - k)) - 1);
        end
        test_reset();
        test_wrap();
        test_skip();
        test_illegal();
        test_load();
        test_hold();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
